// File: rtl/i2s_tx.sv
// i2s_tx: Philips I2S transmitter, clock master.
// Serialises held left/right PCM pairs into BCLK/LRCLK/SDATA.
module i2s_tx #(
    parameter int CLK_DIV      = 2,
    parameter int SAMPLE_WIDTH = 16,
    parameter int SLOT_BITS    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SAMPLE_WIDTH-1:0] left_data,
    input  logic                    left_valid,
    output logic                    left_ready,
    input  logic [SAMPLE_WIDTH-1:0] right_data,
    input  logic                    right_valid,
    output logic                    right_ready,
    output logic                    i2s_bclk,
    output logic                    i2s_lrclk,
    output logic                    i2s_sdata,
    output logic                    frame_start,
    output logic                    underrun
);

    localparam int N  = 2 * SLOT_BITS;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = $clog2(N);
    localparam int PAD = SLOT_BITS - SAMPLE_WIDTH;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [IW-1:0] SLOT_IDX = IW'(SLOT_BITS);

    logic                    left_full;
    logic                    right_full;
    logic [SAMPLE_WIDTH-1:0] left_q;
    logic [SAMPLE_WIDTH-1:0] right_q;

    logic [DW-1:0] div_cnt;
    logic [IW-1:0] bit_idx;
    logic [IW-1:0] idx_next;
    logic [N-1:0]  shreg;

    logic                 tick;
    logic                 fall;
    logic                 load;
    logic                 pair;
    logic [SLOT_BITS-1:0] left_slot;
    logic [SLOT_BITS-1:0] right_slot;
    logic [N-1:0]         frame;

    assign tick     = (div_cnt == DIV_LAST);
    assign fall     = tick && i2s_bclk;
    assign idx_next = (bit_idx == IDX_LAST) ? '0 : bit_idx + 1'b1;
    assign load     = fall && (bit_idx == IDX_LAST);
    assign pair     = left_full && right_full;

    // Samples sit MSB-aligned in their slot; padding below is zero.
    assign left_slot  = SLOT_BITS'(left_q) << PAD;
    assign right_slot = SLOT_BITS'(right_q) << PAD;
    assign frame      = pair ? {left_slot, right_slot} : '0;

    // Ready is the registered empty flag, held low during reset.
    assign left_ready  = !left_full && !rst;
    assign right_ready = !right_full && !rst;

    // Left holding register: filled by handshake, emptied by a paired load.
    always_ff @(posedge clk) begin
        if (rst) begin
            left_full <= 1'b0;
            left_q    <= '0;
        end else if (load && pair) begin
            left_full <= 1'b0;
        end else if (left_valid && !left_full) begin
            left_full <= 1'b1;
            left_q    <= left_data;
        end
    end

    // Right holding register: same policy, independent of the left one.
    always_ff @(posedge clk) begin
        if (rst) begin
            right_full <= 1'b0;
            right_q    <= '0;
        end else if (load && pair) begin
            right_full <= 1'b0;
        end else if (right_valid && !right_full) begin
            right_full <= 1'b1;
            right_q    <= right_data;
        end
    end

    // BCLK divider: toggle every CLK_DIV system clocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= '0;
            i2s_bclk <= 1'b0;
        end else if (tick) begin
            div_cnt  <= '0;
            i2s_bclk <= ~i2s_bclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Serialiser: on each BCLK fall advance the bit index and shift out.
    // The shift register MSB left over after a frame is the previous
    // frame's last bit, which provides the one-bit I2S delay at k=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx     <= IDX_LAST;
            i2s_lrclk   <= 1'b1;
            i2s_sdata   <= 1'b0;
            shreg       <= '0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            if (fall) begin
                bit_idx   <= idx_next;
                i2s_lrclk <= (idx_next >= SLOT_IDX);
                i2s_sdata <= shreg[N-1];
                if (load) begin
                    shreg       <= frame;
                    frame_start <= 1'b1;
                    underrun    <= !pair;
                end else begin
                    shreg <= {shreg[N-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Serialises the stereo PCM stream from the audio sample stage into a Philips I2S bitstream for the board audio codec.
- Sits directly downstream of the audio sample stage. Consumes its left/right valid/ready streams.
- Holds one pending sample per channel.
- Generates BCLK and LRCLK from the system clock; this block is the I2S clock master.

Parameters:
- CLK_DIV, 2, clk cycles per BCLK half-period (min 1).
- SAMPLE_WIDTH, 16, bits per input sample.
- SLOT_BITS, 16, BCLK periods per channel slot (must be >= SAMPLE_WIDTH).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- left_data  in  SAMPLE_WIDTH  left sample, two's complement
- left_valid  in  1  left sample offered
- left_ready  out  1  left holding register empty
- right_data  in  SAMPLE_WIDTH  right sample
- right_valid  in  1  right sample offered
- right_ready  out  1  right holding register empty
- i2s_bclk  out  1  bit clock
- i2s_lrclk  out  1  word select, 0 = left
- i2s_sdata  out  1  serial data
- frame_start  out  1  one-cycle pulse at each frame load
- underrun  out  1  one-cycle pulse when a frame loads silence

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - i2s_bclk=0, i2s_lrclk=1, i2s_sdata=0.
  - frame_start=0, underrun=0.
  - Both holding registers empty.
  - div_cnt=0, bit_idx=2*SLOT_BITS-1.
  - left_ready/right_ready forced 0 while rst=1.
- Input handshake:
  - Per channel, transfer when valid && ready on a rising clk edge.
  - ready = !full (registered flag, no bypass).
  - Accepted data is latched into the holding register; full is set.
  - Channels are independent.
- Clock divider:
  - div_cnt counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps and i2s_bclk toggles.
  - First BCLK rise is CLK_DIV cycles after reset release; first fall is at 2*CLK_DIV.
- Bit index:
  - bit_idx advances (mod 2*SLOT_BITS) in the clk cycle where i2s_bclk falls.
  - i2s_lrclk and i2s_sdata change only in that cycle, so the codec samples them on the BCLK rise.
  - i2s_lrclk = 0 for bit_idx 0..SLOT_BITS-1, else 1.
- Frame load (on the fall that takes bit_idx to 0):
  - If both holding registers are full: frame word F = {L, zeros, R, zeros}, each sample left-justified in its slot, MSB first. Both full flags clear. frame_start=1.
  - Otherwise: F = all zeros. underrun=1, frame_start=1. Any single held sample is retained for the next frame; it is not discarded.
  - A handshake in the load cycle cannot occur, because ready was 0 while full.
- I2S one-bit delay:
  - At bit_idx k, i2s_sdata = F[2*SLOT_BITS-1-(k-1)] for k=1..2*SLOT_BITS-1.
  - At k=0, i2s_sdata = F_prev[0], the right LSB-slot bit of the previous frame (0 after reset).
  - Padding bits are 0.
- Reset mid-frame: all state returns to reset values immediately. The next frame starts fresh; held samples are dropped.
- Implementation scope: holding registers, divider, bit counter, 2*SLOT_BITS shift register plus a delay flop.

Test Plan:
All scenarios use defaults (CLK_DIV=2, SLOT=16); frame = 32 BCLK = 128 clk.
1. Reset release, no input:
   - i2s_bclk rises at cycle 2 and falls at cycle 4 (first falls are at clk 4, 8, 12, ...).
   - At cycle 4: lrclk->0, frame_start=1, underrun=1, sdata stays 0 for the whole frame.
   - ready=1 on both channels.
2. Push L=16'hA5C3, R=16'h0F01 before the first fall:
   - Left slot sdata at k=1..15 = A5C3[15:1], MSB first; A5C3[0] appears at k=16.
   - R at k=17..31 = 0F01[15:1]; bit 0 appears at k=0 of the next frame.
   - lrclk=0 for k=0..15. underrun=0, frame_start=1.
   - Both ready=1 one cycle after the load.
3. Backpressure:
   - Push L=1, then hold left_valid with L=2: left_ready=0 and 2 is not accepted until a frame load.
   - Push R=3: next frame plays L=1/R=3. The following cycle accepts L=2.
4. Partial pair:
   - Push R=16'h8000 only: next frame loads zeros with underrun=1, and right stays full (right_ready=0).
   - Push L=16'h7FFF: the following frame plays 7FFF/8000 with underrun=0.
5. SLOT_BITS=24, L=16'hFFFF, R=16'hFFFF:
   - sdata=1 for k=1..16, 0 for k=17..24, 1 for k=25..40, 0 for k=41..47 and k=0.
6. Assert rst for 1 cycle at k=10 with a pair held:
   - Outputs return to reset values; ready=0 during rst.
   - Next frame_start occurs 4 cycles after release, with underrun=1.
